mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 104 ++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Wait-stated single-port word memory answering a req/ready handshake.
// Each access is latched in IDLE, held for WAIT_CYCLES, then answered with a one-cycle ready strobe.
module mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int         WORDS     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    commit;
  logic                    we_p1, fault_p1;
  logic [DEPTH_LOG2-1:0]   idx_p1;
  logic [31:0]             wdata_p1;
  logic                    acc_we, acc_fault;
  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic [31:0]             acc_wdata;
  logic                    mem_wr;
  logic [31:0]             mem [WORDS];

  function automatic logic addr_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != 32'd0);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            cnt_nxt   = 4'd0;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: request captured at acceptance; later input changes are ignored
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      we_p1    <= we;
      fault_p1 <= addr_fault(addr);
      idx_p1   <= addr[DEPTH_LOG2+1:2];
      wdata_p1 <= wdata;
    end
  end

  // With zero wait states the commit edge is the acceptance edge, so use the live inputs
  assign acc_we    = (state == IDLE) ? we                     : we_p1;
  assign acc_fault = (state == IDLE) ? addr_fault(addr)       : fault_p1;
  assign acc_idx   = (state == IDLE) ? addr[DEPTH_LOG2+1:2]   : idx_p1;
  assign acc_wdata = (state == IDLE) ? wdata                  : wdata_p1;
  assign mem_wr    = reset && commit && acc_we && !acc_fault;

  always_ff @(posedge clk) begin
    if (mem_wr) mem[acc_idx] <= acc_wdata;
  end

  // Stage p2: response, gated so outputs are zero outside the ready strobe
  assign ready = (state == RESP);
  assign err   = ready && fault_p1;
  assign rdata = (ready && !we_p1 && !fault_p1) ? mem[idx_p1] : 32'd0;

endmodule
